// File: rtl/axis_to_avalon_st.sv
// axis_to_avalon_st
// AXI4-Stream (tkeep/tlast/tuser) to Avalon-ST (sop/eop/empty/error) bridge
// feeding the MAC TX client port. Regenerates sop, derives empty from tkeep,
// optionally reverses byte lane order, flags malformed beats and keeps
// frame/error statistics. A two-entry skid buffer (output register plus temp
// register) keeps s_axis_tready registered while sustaining one beat per clock.

module axis_to_avalon_st #(
    parameter int DATA_WIDTH  = 512,
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int EMPTY_WIDTH = 6,
    parameter bit BYTE_SWAP   = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]  s_axis_tkeep,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tuser,

    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    output logic                   out_sop,
    output logic                   out_eop,
    output logic [EMPTY_WIDTH-1:0] out_empty,
    output logic                   out_error,
    input  logic                   out_ready,

    output logic [31:0]            stat_frames,
    output logic [15:0]            stat_errors,
    output logic                   stat_malformed
);

    localparam int                     COUNT_WIDTH     = $clog2(KEEP_WIDTH + 1);
    localparam logic [KEEP_WIDTH-1:0]  KEEP_ONE        = KEEP_WIDTH'(1);
    localparam logic [EMPTY_WIDTH-1:0] EMPTY_ZERO_KEEP = EMPTY_WIDTH'(KEEP_WIDTH - 1);

    // Per-beat Avalon sideband carried alongside the data through the buffer.
    typedef struct packed {
        logic                   sop;
        logic                   eop;
        logic [EMPTY_WIDTH-1:0] empty;
        logic                   error;
    } side_t;

    // ------------------------------------------------------------------
    // Input beat decode (purely combinational, only committed on accept)
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]  swapped_data;
    logic [COUNT_WIDTH-1:0] keep_count;
    logic                   keep_full;
    logic                   keep_zero;
    logic                   keep_contig;
    logic                   beat_malformed;
    logic [EMPTY_WIDTH-1:0] beat_empty;
    side_t                  in_side;
    logic                   in_accept;

    // Frame tracking state.
    logic                   first_beat;
    logic                   frame_err;

    // Skid buffer state and next-state controls.
    side_t                  out_side;
    logic                   temp_valid;
    logic [DATA_WIDTH-1:0]  temp_data;
    side_t                  temp_side;
    logic                   out_valid_next;
    logic                   temp_valid_next;
    logic                   ready_next;
    logic                   store_in_to_out;
    logic                   store_in_to_temp;
    logic                   store_temp_to_out;

    assign in_accept = s_axis_tvalid & s_axis_tready;

    // Lane reordering: AXIS byte 0 becomes the most significant Avalon byte.
    generate
        if (BYTE_SWAP) begin : g_swap
            for (genvar i = 0; i < KEEP_WIDTH; i++) begin : g_lane
                assign swapped_data[DATA_WIDTH-1-8*i -: 8] = s_axis_tdata[8*i +: 8];
            end
        end else begin : g_pass
            assign swapped_data = s_axis_tdata;
        end
    endgenerate

    // Population count of tkeep, used to derive empty on the last beat.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // can leave it unassigned and infer a latch.
        keep_count = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            keep_count = keep_count + COUNT_WIDTH'(s_axis_tkeep[i]);
        end
    end

    // A valid last-beat mask is 2^n-1: adding one clears every set bit.
    assign keep_full   = &s_axis_tkeep;
    assign keep_zero   = ~|s_axis_tkeep;
    assign keep_contig = ~|(s_axis_tkeep & (s_axis_tkeep + KEEP_ONE));

    assign beat_malformed = s_axis_tlast ? (keep_zero | ~keep_contig) : ~keep_full;

    // Empty count: only meaningful on the eop beat; a zero mask is pinned to
    // the largest legal value since Avalon cannot express an empty beat.
    always_comb begin
        beat_empty = '0;
        if (s_axis_tlast) begin
            if (keep_zero) begin
                beat_empty = EMPTY_ZERO_KEEP;
            end else begin
                beat_empty = EMPTY_WIDTH'(KEEP_WIDTH - int'(keep_count));
            end
        end
    end

    // Sideband for the incoming beat; error folds in earlier malformed beats,
    // tuser and the last beat's own mask check, and is only shown on eop.
    always_comb begin
        in_side.sop   = first_beat;
        in_side.eop   = s_axis_tlast;
        in_side.empty = beat_empty;
        in_side.error = s_axis_tlast & (frame_err | s_axis_tuser | beat_malformed);
    end

    // ------------------------------------------------------------------
    // Skid buffer
    // ------------------------------------------------------------------

    // Next-state for the two buffer entries and the registered ready.
    always_comb begin
        out_valid_next    = out_valid;
        temp_valid_next   = temp_valid;
        store_in_to_out   = 1'b0;
        store_in_to_temp  = 1'b0;
        store_temp_to_out = 1'b0;

        // Ready falls only when both entries will be occupied.
        ready_next = out_ready | (~temp_valid & (~out_valid | ~s_axis_tvalid));

        if (s_axis_tready) begin
            // Temp is always empty while ready is high.
            if (out_ready || !out_valid) begin
                out_valid_next  = s_axis_tvalid;
                store_in_to_out = s_axis_tvalid;
            end else begin
                temp_valid_next  = s_axis_tvalid;
                store_in_to_temp = s_axis_tvalid;
            end
        end else if (out_ready) begin
            out_valid_next    = temp_valid;
            temp_valid_next   = 1'b0;
            store_temp_to_out = 1'b1;
        end
    end

    // Control registers of the skid buffer, cleared by reset so any
    // buffered beats are discarded.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register in the design samples pre-edge values.
        if (rst) begin
            out_valid     <= 1'b0;
            temp_valid    <= 1'b0;
            s_axis_tready <= 1'b0;
            out_side      <= '0;
            temp_side     <= '0;
        end else begin
            out_valid     <= out_valid_next;
            temp_valid    <= temp_valid_next;
            s_axis_tready <= ready_next;

            if (store_in_to_out) begin
                out_side <= in_side;
            end else if (store_temp_to_out) begin
                out_side <= temp_side;
            end

            if (store_in_to_temp) begin
                temp_side <= in_side;
            end
        end
    end

    // Wide data registers, loaded on the same strobes as the sideband.
    always_ff @(posedge clk) begin
        // NOTE: data is always qualified by a valid flag, so these registers
        // carry no reset.
        if (store_in_to_out) begin
            out_data <= swapped_data;
        end else if (store_temp_to_out) begin
            out_data <= temp_data;
        end

        if (store_in_to_temp) begin
            temp_data <= swapped_data;
        end
    end

    assign out_sop   = out_side.sop;
    assign out_eop   = out_side.eop;
    assign out_empty = out_side.empty;
    assign out_error = out_side.error;

    // ------------------------------------------------------------------
    // Frame tracking and statistics
    // ------------------------------------------------------------------

    // First-beat flag and error accumulator advance on every accepted beat;
    // the malformed pulse follows acceptance by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_beat     <= 1'b1;
            frame_err      <= 1'b0;
            stat_malformed <= 1'b0;
        end else begin
            stat_malformed <= in_accept & beat_malformed;
            if (in_accept) begin
                first_beat <= s_axis_tlast;
                frame_err  <= s_axis_tlast ? 1'b0 : (frame_err | beat_malformed);
            end
        end
    end

    // Frame and error counters advance when an eop beat leaves the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_frames <= '0;
            stat_errors <= '0;
        end else if (out_valid && out_ready && out_side.eop) begin
            stat_frames <= stat_frames + 32'd1;
            if (out_side.error && (stat_errors != 16'hFFFF)) begin
                stat_errors <= stat_errors + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_axis_to_avalon_st.sv
// tb_axis_to_avalon_st
// Directed scoreboard bench: the driver pushes the hand-specified Avalon beat
// for every accepted AXIS beat; an independent monitor pops and compares each
// output transfer, checks hold-while-stalled and the tready occupancy rule.

`timescale 1ns/1ps

module tb_axis_to_avalon_st;

    localparam int DW = 512;
    localparam int KW = 64;
    localparam int EW = 6;

    localparam logic [KW-1:0] KEEP_ALL = '1;

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [KW-1:0] s_axis_tkeep = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tuser = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_sop;
    logic          out_eop;
    logic [EW-1:0] out_empty;
    logic          out_error;
    logic          out_ready = 1'b1;
    logic [31:0]   stat_frames;
    logic [15:0]   stat_errors;
    logic          stat_malformed;

    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];
    int   mal_seen = 0;
    int   acc_cnt = 0;
    int   out_cnt = 0;
    int   beat_no = 0;
    int   ready_skip = 1;
    logic prev_stall = 1'b0;
    exp_t snap;

    logic       ready_pat[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    logic [1:0] ready_idx = 2'd0;

    axis_to_avalon_st #(
        .DATA_WIDTH (DW),
        .KEEP_WIDTH (KW),
        .EMPTY_WIDTH(EW),
        .BYTE_SWAP  (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_sop       (out_sop),
        .out_eop       (out_eop),
        .out_empty     (out_empty),
        .out_error     (out_error),
        .out_ready     (out_ready),
        .stat_frames   (stat_frames),
        .stat_errors   (stat_errors),
        .stat_malformed(stat_malformed)
    );

    initial forever #5 clk = ~clk;

    // Sink ready follows a repeating 4-step pattern, changed 2ns after posedge.
    initial forever begin
        @(posedge clk);
        #2;
        out_ready = ready_pat[ready_idx];
        ready_idx = ready_idx + 2'd1;
    end

    // Byte i of the AXIS beat is seed+i.
    function automatic logic [DW-1:0] mk_data(input logic [7:0] seed);
        logic [DW-1:0] d;
        for (int i = 0; i < KW; i++) d[8*i +: 8] = seed + 8'(i);
        return d;
    endfunction

    // Avalon lane order: AXIS byte i lands in byte KW-1-i.
    function automatic logic [DW-1:0] swap_bytes(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        for (int i = 0; i < KW; i++) r[8*(KW-1-i) +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Drive one beat from posedge+1; push its expected output on acceptance.
    task automatic send(input logic [7:0] seed, input logic [KW-1:0] keep, input logic last,
                        input logic user, input logic e_sop, input logic [EW-1:0] e_empty,
                        input logic e_err);
        exp_t e;
        int   waited = 0;
        s_axis_tdata  = mk_data(seed);
        s_axis_tkeep  = keep;
        s_axis_tlast  = last;
        s_axis_tuser  = user;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!s_axis_tready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: tready=0 after %0d cycles, want 1", waited);
        end else begin
            e.data  = swap_bytes(mk_data(seed));
            e.sop   = e_sop;
            e.eop   = last;
            e.empty = e_empty;
            e.err   = e_err;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d beats still expected, want 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: compares outputs on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            acc_cnt    = 0;
            out_cnt    = 0;
            prev_stall = 1'b0;
            ready_skip = 1;
        end else begin
            if (ready_skip > 0) begin
                ready_skip--;
            end else begin
                check("tready_rule", 64'(s_axis_tready), 64'((acc_cnt - out_cnt) != 2));
            end

            if (prev_stall) begin
                total++;
                if (out_data !== snap.data || out_sop !== snap.sop || out_eop !== snap.eop ||
                    out_empty !== snap.empty || out_error !== snap.err || out_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL stall_hold: got v=%b sop=%b eop=%b empty=%0d err=%b want v=1 sop=%b eop=%b empty=%0d err=%b",
                             out_valid, out_sop, out_eop, out_empty, out_error,
                             snap.sop, snap.eop, snap.empty, snap.err);
                end
            end

            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat: got beat with sop=%b eop=%b, want none", out_sop, out_eop);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (out_data !== e.data || out_sop !== e.sop || out_eop !== e.eop ||
                        out_empty !== e.empty || out_error !== e.err) begin
                        bad++;
                        $display("FAIL beat_%0d: got sop=%b eop=%b empty=%0d err=%b data=%h want sop=%b eop=%b empty=%0d err=%b data=%h",
                                 beat_no, out_sop, out_eop, out_empty, out_error, out_data,
                                 e.sop, e.eop, e.empty, e.err, e.data);
                    end
                end
                beat_no++;
            end

            if (stat_malformed) mal_seen++;
            if (s_axis_tvalid && s_axis_tready) acc_cnt++;
            if (out_valid && out_ready) out_cnt++;

            prev_stall = out_valid && !out_ready;
            snap.data  = out_data;
            snap.sop   = out_sop;
            snap.eop   = out_eop;
            snap.empty = out_empty;
            snap.err   = out_error;
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_sop"}, 64'(out_sop), 64'(0));
        check({tag, "_eop"}, 64'(out_eop), 64'(0));
        check({tag, "_empty"}, 64'(out_empty), 64'(0));
        check({tag, "_error"}, 64'(out_error), 64'(0));
        check({tag, "_tready"}, 64'(s_axis_tready), 64'(0));
        check({tag, "_malformed"}, 64'(stat_malformed), 64'(0));
        check({tag, "_frames"}, 64'(stat_frames), 64'(0));
        check({tag, "_errors"}, 64'(stat_errors), 64'(0));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("rst0");
        @(posedge clk);
        #1;

        // Single-beat frame, 16 valid bytes.
        send(8'h10, 64'h0000_0000_0000_FFFF, 1'b1, 1'b0, 1'b1, 6'd48, 1'b0);
        @(negedge clk);
        check("single_latency_valid", 64'(out_valid), 64'(1));
        check("single_sop", 64'(out_sop), 64'(1));
        check("single_eop", 64'(out_eop), 64'(1));
        @(posedge clk);
        #1;
        wait_drain();
        check("single_frames", 64'(stat_frames), 64'(1));
        check("single_errors", 64'(stat_errors), 64'(0));

        // Three-beat frame, byte 0 = 0xAA on the first beat.
        send(8'hAA, KEEP_ALL, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0);
        @(negedge clk);
        check("swap_byte0_msb", 64'(out_data[DW-1 -: 8]), 64'hAA);
        check("swap_sop", 64'(out_sop), 64'(1));
        @(posedge clk);
        #1;
        send(8'h40, KEEP_ALL, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        send(8'h80, 64'h0000_0000_0000_00FF, 1'b1, 1'b0, 1'b0, 6'd56, 1'b0);
        wait_drain();
        check("three_frames", 64'(stat_frames), 64'(2));

        // Back-to-back frames with the sink stalling 1,0,0,1.
        ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        send(8'h01, KEEP_ALL, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0);
        send(8'h02, KEEP_ALL, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        send(8'h03, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 6'd32, 1'b0);
        send(8'h04, KEEP_ALL, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0);
        send(8'h05, KEEP_ALL, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        send(8'h06, 64'h0000_0000_0000_0001, 1'b1, 1'b0, 1'b1, 6'd63, 1'b0);
        wait_drain();
        ready_pat = '{1'b1, 1'b1, 1'b1, 1'b1};
        check("stall_frames", 64'(stat_frames), 64'(5));
        check("stall_errors", 64'(stat_errors), 64'(0));

        // Malformed middle beat taints the frame's eop; next frame is clean.
        send(8'h20, KEEP_ALL, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0);
        send(8'h21, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        @(negedge clk);
        check("mid_malformed_pulse", 64'(stat_malformed), 64'(1));
        @(posedge clk);
        #1;
        send(8'h22, KEEP_ALL, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1);
        send(8'h23, 64'h0000_0000_0000_FFFF, 1'b1, 1'b0, 1'b1, 6'd48, 1'b0);
        wait_drain();
        check("mal_frames", 64'(stat_frames), 64'(7));
        check("mal_errors", 64'(stat_errors), 64'(1));
        check("mal_pulses", 64'(mal_seen), 64'(1));

        // Last-beat corner cases: zero mask, tuser, holes in the mask.
        send(8'h30, 64'h0, 1'b1, 1'b0, 1'b1, 6'd63, 1'b1);
        send(8'h31, 64'h0000_0000_0000_00FF, 1'b1, 1'b1, 1'b1, 6'd56, 1'b1);
        send(8'h32, 64'h0000_0000_0000_0005, 1'b1, 1'b0, 1'b1, 6'd62, 1'b1);
        send(8'h33, KEEP_ALL, 1'b1, 1'b0, 1'b1, 6'd0, 1'b0);
        wait_drain();
        check("last_frames", 64'(stat_frames), 64'(11));
        check("last_errors", 64'(stat_errors), 64'(4));
        check("last_pulses", 64'(mal_seen), 64'(3));

        // Reset after the second beat of a four-beat frame.
        send(8'h50, KEEP_ALL, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0);
        send(8'h51, KEEP_ALL, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("rst1");
        @(posedge clk);
        #1;
        send(8'h52, KEEP_ALL, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0);
        send(8'h53, KEEP_ALL, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        wait_drain();
        check("post_rst_frames", 64'(stat_frames), 64'(1));
        check("post_rst_errors", 64'(stat_errors), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
